// File: rtl/i2c_write_master_if.sv
// Request/status and open-drain line bundle between the configuration queue,
// the I2C write master and the HDMI transmitter pins.
interface i2c_write_master_if;
  logic       start;
  logic [6:0] address;
  logic [7:0] data_0;
  logic [7:0] data_1;
  logic       busy;
  logic       done;
  logic       ack_error;
  logic       scl_oe;
  logic       sda_oe;
  logic       sda_in;

  modport master (
    input  start, address, data_0, data_1, sda_in,
    output busy, done, ack_error, scl_oe, sda_oe
  );

  modport slave (
    output start, address, data_0, data_1, sda_in,
    input  busy, done, ack_error, scl_oe, sda_oe
  );
endinterface

// File: rtl/i2c_write_master.sv
// Single-transaction I2C write master: START, addr+W, data_0, data_1, STOP,
// four quarter-periods per bit, with sticky NACK reporting.
module i2c_write_master #(
  parameter int QDIV = 125
) (
  input  logic             clk,
  input  logic             rst,
  i2c_write_master_if.master bus
);

  localparam int QW = (QDIV > 1) ? $clog2(QDIV) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    BYTE,
    ACK,
    STOP
  } state_t;

  state_t       state;
  state_t       state_next;
  logic [QW-1:0] qcnt;
  logic [1:0]   quarter;
  logic [3:0]   bit_cnt;
  logic [1:0]   byte_idx;
  logic [7:0]   shreg;
  logic [7:0]   d0_q;
  logic [7:0]   d1_q;
  logic         ack_error_q;
  logic         done_q;
  logic         done_next;
  logic         scl_oe_c;
  logic         sda_oe_c;
  logic         tick;
  logic         last_q;

  assign tick   = (qcnt == QW'(QDIV - 1));
  assign last_q = tick && (quarter == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      done_q <= 1'b0;
    end else begin
      state  <= state_next;
      done_q <= done_next;
    end
  end

  // Quarter timing, shift register and NACK capture; the counter is held at
  // zero in IDLE so every transaction starts on a fresh quarter.
  always_ff @(posedge clk) begin
    if (rst) begin
      qcnt        <= '0;
      quarter     <= 2'd0;
      bit_cnt     <= 4'd0;
      byte_idx    <= 2'd0;
      shreg       <= 8'd0;
      d0_q        <= 8'd0;
      d1_q        <= 8'd0;
      ack_error_q <= 1'b0;
    end else if (state == IDLE) begin
      qcnt    <= '0;
      quarter <= 2'd0;
      if (bus.start) begin
        shreg       <= {bus.address, 1'b0};
        d0_q        <= bus.data_0;
        d1_q        <= bus.data_1;
        ack_error_q <= 1'b0;
        bit_cnt     <= 4'd0;
        byte_idx    <= 2'd0;
      end
    end else begin
      qcnt <= tick ? '0 : qcnt + 1'b1;
      if (tick) begin
        quarter <= quarter + 2'd1;
      end
      if ((state == ACK) && (quarter == 2'd2) && tick && bus.sda_in) begin
        ack_error_q <= 1'b1;
      end
      if (last_q && (state == BYTE)) begin
        bit_cnt <= (bit_cnt == 4'd7) ? 4'd0 : bit_cnt + 4'd1;
        shreg   <= {shreg[6:0], 1'b0};
      end
      if (last_q && (state == ACK)) begin
        byte_idx <= byte_idx + 2'd1;
        shreg    <= (byte_idx == 2'd0) ? d0_q : d1_q;
      end
    end
  end

  // Line pattern per quarter and state sequencing. A NACK recorded in q2 of
  // the ACK bit is already visible at the end of q3 and diverts to STOP.
  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    scl_oe_c   = 1'b0;
    sda_oe_c   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_next = START;
        end
      end
      START: begin
        sda_oe_c = quarter[1];
        if (last_q) begin
          state_next = BYTE;
        end
      end
      BYTE: begin
        scl_oe_c = ~quarter[1];
        sda_oe_c = ~shreg[7];
        if (last_q && (bit_cnt == 4'd7)) begin
          state_next = ACK;
        end
      end
      ACK: begin
        scl_oe_c = ~quarter[1];
        if (last_q) begin
          state_next = (ack_error_q || (byte_idx == 2'd2)) ? STOP : BYTE;
        end
      end
      STOP: begin
        scl_oe_c = (quarter == 2'd0);
        sda_oe_c = ~quarter[1];
        if (last_q) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;
  assign bus.ack_error = ack_error_q;
  assign bus.scl_oe    = scl_oe_c;
  assign bus.sda_oe    = sda_oe_c;

endmodule

// File: tb/tb_i2c_write_master.sv
// Bench for i2c_write_master: a transaction-level waveform model checked every
// cycle, a small ACK/NACK slave, and hand-computed byte/duration expectations.
module tb_i2c_write_master;

  localparam int QDIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  i2c_write_master_if bus();

  i2c_write_master #(.QDIV(QDIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic busy;
    logic done;
    logic scl;
    logic sda;
    logic aerr;
  } exp_t;

  exp_t exp_q[$];
  logic m_aerr = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic pull = 1'b0;
  assign bus.sda_in = ~(bus.sda_oe | pull);

  logic prev_scl = 1'b0;
  int   rises = 0;
  logic cap_bits[$];
  int   done_total = 0;
  int   busy_run = 0;
  int   last_busy_run = 0;
  int   idle_run = 0;
  int   last_idle_run = 0;
  int   nack_byte = 3;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  task automatic push_q(input logic scl, input logic sda, input logic aerr);
    exp_t e;
    e.busy = 1'b1;
    e.done = 1'b0;
    e.scl  = scl;
    e.sda  = sda;
    e.aerr = aerr;
    repeat (QDIV) exp_q.push_back(e);
  endtask

  // Expected line/status waveform of one whole transaction, cycle by cycle,
  // starting the cycle after acceptance and ending with the done cycle.
  task automatic build(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input int nb);
    logic [7:0] bytes [3];
    logic       aerr;
    exp_t       e;
    aerr = 1'b0;
    bytes[0] = b0;
    bytes[1] = b1;
    bytes[2] = b2;
    push_q(1'b0, 1'b0, 1'b0);
    push_q(1'b0, 1'b0, 1'b0);
    push_q(1'b0, 1'b1, 1'b0);
    push_q(1'b0, 1'b1, 1'b0);
    for (int b = 0; b < 3; b++) begin
      for (int i = 7; i >= 0; i--) begin
        logic s;
        s = ~bytes[b][i];
        push_q(1'b1, s, 1'b0);
        push_q(1'b1, s, 1'b0);
        push_q(1'b0, s, 1'b0);
        push_q(1'b0, s, 1'b0);
      end
      push_q(1'b1, 1'b0, 1'b0);
      push_q(1'b1, 1'b0, 1'b0);
      push_q(1'b0, 1'b0, 1'b0);
      if (b == nb) aerr = 1'b1;
      push_q(1'b0, 1'b0, aerr);
      if (b == nb) break;
    end
    push_q(1'b1, 1'b1, aerr);
    push_q(1'b0, 1'b1, aerr);
    push_q(1'b0, 1'b0, aerr);
    push_q(1'b0, 1'b0, aerr);
    e.busy = 1'b0;
    e.done = 1'b1;
    e.scl  = 1'b0;
    e.sda  = 1'b0;
    e.aerr = aerr;
    exp_q.push_back(e);
  endtask

  // One clock: model the edge, compare all outputs, update slave and monitors.
  task automatic tick();
    logic       rst_s, start_s, rise;
    logic [6:0] a_s;
    logic [7:0] d0_s, d1_s;
    exp_t       e, got;
    @(posedge clk);
    rst_s   = rst;
    start_s = bus.start;
    a_s     = bus.address;
    d0_s    = bus.data_0;
    d1_s    = bus.data_1;
    #1;
    if (rst_s) begin
      exp_q.delete();
      m_aerr = 1'b0;
    end else if (start_s && (exp_q.size() == 0)) begin
      build({a_s, 1'b0}, d0_s, d1_s, nack_byte);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      m_aerr = e.aerr;
    end else begin
      e = '{busy: 1'b0, done: 1'b0, scl: 1'b0, sda: 1'b0, aerr: m_aerr};
    end
    got = {bus.busy, bus.done, bus.scl_oe, bus.sda_oe, bus.ack_error};
    checkOutput("cycle busy/done/scl/sda/aerr", 32'(got), 32'(e));

    rise = 1'b0;
    if (bus.busy !== 1'b1) begin
      rises = 0;
      pull  = 1'b0;
    end else begin
      if (prev_scl && !bus.scl_oe) begin
        rises++;
        rise = 1'b1;
      end
      pull = (rises > 0) && (rises % 9 == 0) && !bus.scl_oe && ((rises / 9 - 1) != nack_byte);
      if (rise) cap_bits.push_back(~(bus.sda_oe | pull));
    end
    prev_scl = bus.scl_oe;

    if (bus.done === 1'b1) done_total++;
    if (bus.busy === 1'b1) begin
      busy_run++;
      if (idle_run > 0) begin
        last_idle_run = idle_run;
        idle_run = 0;
      end
    end else begin
      if (busy_run > 0) begin
        last_busy_run = busy_run;
        busy_run = 0;
      end
      idle_run++;
    end
  endtask

  task automatic applyStimulus(input logic [6:0] a, input logic [7:0] d0, input logic [7:0] d1, input int nb);
    bus.address = a;
    bus.data_0  = d0;
    bus.data_1  = d1;
    nack_byte   = nb;
    bus.start   = 1'b1;
  endtask

  task automatic wait_done(input int limit);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("done_within_budget", 32'(seen), 32'd1);
  endtask

  function automatic logic [7:0] get_byte(input int idx);
    logic [7:0] v;
    v = 8'h00;
    for (int i = 0; i < 8; i++) v = {v[6:0], cap_bits[idx + i]};
    return v;
  endfunction

  int base;
  int dbase;

  initial begin
    bus.start   = 1'b0;
    bus.address = 7'h00;
    bus.data_0  = 8'h00;
    bus.data_1  = 8'h00;
    rst = 1'b1;
    repeat (3) tick();
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    checkOutput("reset_lines", 32'({bus.scl_oe, bus.sda_oe}), 32'd0);
    rst = 1'b0;
    repeat (2) tick();

    // normal write, all ACKed
    applyStimulus(7'h72, 8'h01, 8'h00, 3);
    base = cap_bits.size(); dbase = done_total;
    tick();
    bus.start = 1'b0;
    wait_done(600);
    checkOutput("t1_byte0", 32'(get_byte(base)), 32'hE4);
    checkOutput("t1_byte1", 32'(get_byte(base + 9)), 32'h01);
    checkOutput("t1_byte2", 32'(get_byte(base + 18)), 32'h00);
    checkOutput("t1_ack0", 32'(cap_bits[base + 8]), 32'd0);
    checkOutput("t1_rises", cap_bits.size() - base, 28);
    checkOutput("t1_busy_cycles", last_busy_run, 464);
    checkOutput("t1_done_pulses", done_total - dbase, 1);
    checkOutput("t1_ack_error", 32'(bus.ack_error), 32'd0);
    repeat (3) tick();

    // address NACK
    applyStimulus(7'h3C, 8'hA5, 8'h5A, 0);
    base = cap_bits.size(); dbase = done_total;
    tick();
    bus.start = 1'b0;
    wait_done(600);
    checkOutput("t2_byte0", 32'(get_byte(base)), 32'h78);
    checkOutput("t2_nack_bit", 32'(cap_bits[base + 8]), 32'd1);
    checkOutput("t2_rises", cap_bits.size() - base, 10);
    checkOutput("t2_busy_cycles", last_busy_run, 176);
    checkOutput("t2_done_pulses", done_total - dbase, 1);
    checkOutput("t2_ack_error", 32'(bus.ack_error), 32'd1);
    repeat (2) tick();

    // data_0 NACK, then a clean write clears the sticky error
    applyStimulus(7'h72, 8'h1A, 8'hFF, 1);
    base = cap_bits.size();
    tick();
    bus.start = 1'b0;
    wait_done(600);
    checkOutput("t3_byte1", 32'(get_byte(base + 9)), 32'h1A);
    checkOutput("t3_rises", cap_bits.size() - base, 19);
    checkOutput("t3_busy_cycles", last_busy_run, 320);
    checkOutput("t3_ack_error", 32'(bus.ack_error), 32'd1);
    repeat (2) tick();
    applyStimulus(7'h72, 8'h15, 8'h38, 3);
    base = cap_bits.size();
    tick();
    bus.start = 1'b0;
    checkOutput("t3_aerr_cleared", 32'(bus.ack_error), 32'd0);
    wait_done(600);
    checkOutput("t3b_byte2", 32'(get_byte(base + 18)), 32'h38);
    checkOutput("t3b_busy_cycles", last_busy_run, 464);
    repeat (2) tick();

    // start pulses while busy are ignored
    applyStimulus(7'h39, 8'hC3, 8'h3C, 3);
    base = cap_bits.size();
    tick();
    bus.start = 1'b0;
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 600; i++) begin
        if (i % 37 == 5) begin
          bus.start   = 1'b1;
          bus.address = 7'(i + 17);
          bus.data_0  = 8'(i * 3);
          bus.data_1  = 8'(i + 99);
        end else begin
          bus.start = 1'b0;
        end
        tick();
        if (bus.done === 1'b1) begin
          seen = 1'b1;
          break;
        end
      end
      bus.start = 1'b0;
      checkOutput("t4_done_within_budget", 32'(seen), 32'd1);
    end
    checkOutput("t4_byte0", 32'(get_byte(base)), 32'h72);
    checkOutput("t4_byte1", 32'(get_byte(base + 9)), 32'hC3);
    checkOutput("t4_byte2", 32'(get_byte(base + 18)), 32'h3C);
    repeat (2) tick();

    // reset in the middle of the data_0 first bit
    applyStimulus(7'h72, 8'hF0, 8'h0F, 3);
    tick();
    bus.start = 1'b0;
    repeat (170) tick();
    rst = 1'b1;
    tick();
    checkOutput("t5_busy_after_rst", 32'(bus.busy), 32'd0);
    checkOutput("t5_lines_after_rst", 32'({bus.scl_oe, bus.sda_oe}), 32'd0);
    checkOutput("t5_done_after_rst", 32'(bus.done), 32'd0);
    rst = 1'b0;
    tick();
    applyStimulus(7'h4D, 8'h96, 8'h69, 3);
    base = cap_bits.size();
    tick();
    bus.start = 1'b0;
    wait_done(600);
    checkOutput("t5_byte0", 32'(get_byte(base)), 32'h9A);
    checkOutput("t5_byte1", 32'(get_byte(base + 9)), 32'h96);
    checkOutput("t5_byte2", 32'(get_byte(base + 18)), 32'h69);
    checkOutput("t5_busy_cycles", last_busy_run, 464);
    repeat (2) tick();

    // back-to-back with start held through the done cycle
    applyStimulus(7'h72, 8'h01, 8'h00, 3);
    wait_done(600);
    bus.data_0 = 8'h55;
    base = cap_bits.size();
    tick();
    bus.start = 1'b0;
    checkOutput("t6_busy_again", 32'(bus.busy), 32'd1);
    checkOutput("t6_idle_gap", last_idle_run, 1);
    wait_done(600);
    checkOutput("t6_byte0", 32'(get_byte(base)), 32'hE4);
    checkOutput("t6_byte1", 32'(get_byte(base + 9)), 32'h55);
    checkOutput("t6_busy_cycles", last_busy_run, 464);
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
